// File: rtl/step_input_ctrl.sv
// Button-to-step controller: turns two debounced push-button levels into one-cycle
// step strobes, arbitrates overlapping presses, enforces a release hold-off and counts groups.
module step_input_ctrl #(
    parameter int unsigned HOLDOFF = 50000,
    parameter int unsigned GROUP   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       btn0,
    input  logic       btn1,
    output logic       step,
    output logic       step_bit,
    output logic [3:0] step_count,
    output logic       group_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_ARM      = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PRESSED  = 3'd2,
        ST_CONFLICT = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    localparam logic [3:0]  GROUP_LAST = 4'(GROUP - 1);
    localparam logic [15:0] HOLD_LOAD  = 16'(HOLDOFF - 1);

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        step_q, step_d;
    logic        step_bit_q, step_bit_d;
    logic [3:0]  count_q, count_d;
    logic        group_done_q, group_done_d;
    logic        busy_q, busy_d;
    logic        any_btn_s;
    logic        both_low_s;

    assign any_btn_s  = btn0 | btn1;
    assign both_low_s = ~any_btn_s;

    // Next-state, strobe and group-count logic; outputs are computed one edge ahead.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        step_d       = 1'b0;
        step_bit_d   = step_bit_q;
        count_d      = count_q;
        group_done_d = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (both_low_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_IDLE: begin
                if (btn0 ^ btn1) begin
                    state_d    = ST_PRESSED;
                    step_d     = 1'b1;
                    step_bit_d = btn1;
                    if (count_q == GROUP_LAST) begin
                        count_d      = 4'd0;
                        group_done_d = 1'b1;
                    end else begin
                        count_d      = count_q + 4'd1;
                        group_done_d = 1'b0;
                    end
                end else if (btn0 && btn1) begin
                    state_d = ST_CONFLICT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESSED, ST_CONFLICT: begin
                if (both_low_s) begin
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                // A button still down at expiry must be released again before it counts.
                if (hold_q == 16'd0) begin
                    state_d = any_btn_s ? ST_ARM : ST_IDLE;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_ARM;
            hold_q       <= 16'd0;
            step_q       <= 1'b0;
            step_bit_q   <= 1'b0;
            count_q      <= 4'd0;
            group_done_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            step_q       <= step_d;
            step_bit_q   <= step_bit_d;
            count_q      <= count_d;
            group_done_q <= group_done_d;
            busy_q       <= busy_d;
        end
    end

    assign step       = step_q;
    assign step_bit   = step_bit_q;
    assign step_count = count_q;
    assign group_done = group_done_q;
    assign busy       = busy_q;

endmodule
